// File: rtl/vdic_dut_pkg.sv
// Shared types and constants for the VDIC serial front-end.
package vdic_dut_pkg;
  localparam int RX_WORD_W = 10;
  localparam int MAX_DATA  = 8;

  typedef enum logic [1:0] {
    RX_OK       = 2'd0,
    RX_PARITY   = 2'd1,
    RX_OVERFLOW = 2'd2,
    RX_FRAMING  = 2'd3
  } rx_status_t;

  typedef enum logic [1:0] {IDLE, RX, DONE, WAIT_IDLE} rx_state_t;
endpackage

// File: rtl/vdic_rx_word.sv
// Serial word assembler: shift register, bit counter and parity check.
// Word outputs are combinational on the cycle the parity bit is sampled.
module vdic_rx_word #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_i,
  input  logic              clr_i,
  input  logic              din_i,
  output logic              word_done_o,
  output logic              word_flag_o,
  output logic [DATA_W-1:0] word_payload_o,
  output logic              word_perr_o
);
  localparam int WW = DATA_W + 2;
  localparam int CW = $clog2(WW);

  logic [WW-2:0] sr_q;
  logic [CW-1:0] cnt_q;
  logic [WW-1:0] word;

  assign word           = {sr_q, din_i};
  assign word_done_o    = shift_i && (cnt_q == CW'(WW-1));
  assign word_flag_o    = word[WW-1];
  assign word_payload_o = word[WW-2:1];
  assign word_perr_o    = (^word[WW-2:1]) != word[0];

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= word[WW-2:0];
      cnt_q <= word_done_o ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/vdic_serial_rx.sv
// Serial frame receiver: collects operand/command words, records the first
// error seen, and hands one frame result per attempt to a one-entry holding register.
module vdic_serial_rx #(
  parameter int DATA_W   = 8,
  parameter int MAX_DATA = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_n,
  input  logic                         din,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            frame_cmd,
  output logic [$clog2(MAX_DATA+1)-1:0] frame_size,
  output logic [MAX_DATA*DATA_W-1:0]   frame_data,
  output vdic_dut_pkg::rx_status_t     frame_status,
  output logic [7:0]                   drop_cnt
);
  import vdic_dut_pkg::*;

  localparam int SW = $clog2(MAX_DATA+1);
  localparam int IW = $clog2(MAX_DATA);

  rx_state_t                        state_q, state_d;
  logic [SW-1:0]                    cnt_q, cnt_d;
  logic [MAX_DATA-1:0][DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]                cmd_q, cmd_d;
  rx_status_t                       err_q, err_d;
  logic                             shift, clr, load;

  logic              word_done, word_flag, word_perr;
  logic [DATA_W-1:0] word_payload;

  vdic_rx_word #(.DATA_W(DATA_W)) u_word (
    .clk            (clk),
    .rst            (rst),
    .shift_i        (shift),
    .clr_i          (clr),
    .din_i          (din),
    .word_done_o    (word_done),
    .word_flag_o    (word_flag),
    .word_payload_o (word_payload),
    .word_perr_o    (word_perr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      cmd_q   <= '0;
      err_q   <= RX_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
    end
  end

  // err_d is re-read within a word so parity takes precedence over overflow
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    shift   = 1'b0;
    clr     = 1'b1;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!enable_n) begin
          shift   = 1'b1;
          clr     = 1'b0;
          state_d = RX;
        end
      end
      RX: begin
        clr = 1'b0;
        if (enable_n) begin
          if (err_d == RX_OK) err_d = RX_FRAMING;
          state_d = DONE;
        end else begin
          shift = 1'b1;
          if (word_done) begin
            if (word_perr && err_d == RX_OK) err_d = RX_PARITY;
            if (word_flag) begin
              cmd_d   = word_payload;
              state_d = DONE;
            end else if (cnt_q != SW'(MAX_DATA)) begin
              data_d[cnt_q[IW-1:0]] = word_payload;
              cnt_d = cnt_q + 1'b1;
            end else if (err_d == RX_OK) begin
              err_d = RX_OVERFLOW;
            end
          end
        end
      end
      DONE: begin
        load    = 1'b1;
        cnt_d   = '0;
        data_d  = '0;
        cmd_d   = '0;
        err_d   = RX_OK;
        state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (enable_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic                        ovld_q;
  logic [DATA_W-1:0]           ocmd_q;
  logic [SW-1:0]               osize_q;
  logic [MAX_DATA*DATA_W-1:0]  odata_q;
  rx_status_t                  ostat_q;
  logic [7:0]                  drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovld_q  <= 1'b0;
      ocmd_q  <= '0;
      osize_q <= '0;
      odata_q <= '0;
      ostat_q <= RX_OK;
      drop_q  <= '0;
    end else if (load && (!ovld_q || out_ready)) begin
      ovld_q  <= 1'b1;
      ocmd_q  <= cmd_q;
      osize_q <= cnt_q;
      odata_q <= data_q;
      ostat_q <= err_q;
    end else begin
      if (ovld_q && out_ready) ovld_q <= 1'b0;
      if (load && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign out_valid    = ovld_q;
  assign frame_cmd    = ocmd_q;
  assign frame_size   = osize_q;
  assign frame_data   = odata_q;
  assign frame_status = ostat_q;
  assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_vdic_serial_rx.sv
// Randomized and directed bench for vdic_serial_rx with a frame-level reference model.
module tb_vdic_serial_rx;
  import vdic_dut_pkg::*;

  logic        clk = 1'b0;
  logic        rst, enable_n, din, out_valid, out_ready;
  logic [7:0]  frame_cmd, drop_cnt;
  logic [3:0]  frame_size;
  logic [63:0] frame_data;
  rx_status_t  frame_status;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  vdic_serial_rx #(.DATA_W(8), .MAX_DATA(8)) dut (
    .clk(clk), .rst(rst), .enable_n(enable_n), .din(din),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_cmd(frame_cmd), .frame_size(frame_size), .frame_data(frame_data),
    .frame_status(frame_status), .drop_cnt(drop_cnt)
  );

  typedef logic [77:0] res_t;  // {cmd, size, data, status}
  res_t got_q[$];

  always @(posedge clk)
    if (out_valid && out_ready)
      got_q.push_back({frame_cmd, frame_size, frame_data, 2'(frame_status)});

  // Current frame description
  int         fr_n;
  logic [7:0] fr_pl [16];
  logic       fr_bad[16];
  logic [7:0] fr_cmd;
  logic       fr_has_cmd, fr_bad_cmd;
  int         fr_trunc;

  function automatic res_t cur_out();
    return {frame_cmd, frame_size, frame_data, 2'(frame_status)};
  endfunction

  // Status is the first error in time: earliest bad-parity word, the ninth data
  // word, or a missing command at the end of the frame.
  function automatic res_t model();
    logic [63:0] d = '0;
    logic [3:0]  s;
    logic [7:0]  c;
    int first_par = 1000, first_ovf = 1000, first_frm = 1000;
    logic [1:0]  st;
    for (int i = 0; i < fr_n; i++) if (i < 8) d[8*i +: 8] = fr_pl[i];
    s = (fr_n > 8) ? 4'd8 : 4'(fr_n);
    c = fr_has_cmd ? fr_cmd : 8'h00;
    for (int i = fr_n - 1; i >= 0; i--) if (fr_bad[i]) first_par = i;
    if (fr_has_cmd && fr_bad_cmd && first_par == 1000) first_par = fr_n;
    if (fr_n > 8) first_ovf = 8;
    if (!fr_has_cmd) first_frm = fr_n + 1;
    if (first_par <= first_ovf && first_par <= first_frm && first_par != 1000) st = 2'd1;
    else if (first_ovf < first_frm) st = 2'd2;
    else if (first_frm != 1000) st = 2'd3;
    else st = 2'd0;
    return {c, s, d, st};
  endfunction

  task automatic send_word(input logic flag, input logic [7:0] pl, input logic bad, input int nbits);
    logic [9:0] w;
    w = {flag, pl, (^pl) ^ bad};
    for (int b = 9; b > 9 - nbits; b--) begin
      @(negedge clk); enable_n = 1'b0; din = w[b];
    end
  endtask

  task automatic end_frame();
    @(negedge clk); enable_n = 1'b1; din = 1'b0;
  endtask

  task automatic send_cur();
    for (int i = 0; i < fr_n; i++) send_word(1'b0, fr_pl[i], fr_bad[i], 10);
    if (fr_has_cmd) send_word(1'b1, fr_cmd, fr_bad_cmd, 10);
    else if (fr_trunc > 0) send_word(1'b0, 8'($urandom), 1'b0, fr_trunc);
    end_frame();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_result(output res_t r);
    bit ok = 0;
    r = 'x;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (got_q.size() > 0) begin r = got_q.pop_front(); ok = 1; end
      else @(negedge clk);
    end
  endtask

  task automatic clear_frame();
    fr_n = 0; fr_cmd = 0; fr_has_cmd = 1; fr_bad_cmd = 0; fr_trunc = 0;
    for (int i = 0; i < 16; i++) begin fr_pl[i] = 0; fr_bad[i] = 0; end
  endtask

  task automatic rand_frame(input bit clean);
    clear_frame();
    fr_n = clean ? $urandom_range(0, 8) : $urandom_range(0, 10);
    for (int i = 0; i < fr_n; i++) begin
      fr_pl[i]  = 8'($urandom);
      fr_bad[i] = clean ? 1'b0 : ($urandom_range(0, 7) == 0);
    end
    fr_cmd     = 8'($urandom);
    fr_has_cmd = clean ? 1'b1 : ($urandom_range(0, 4) != 0);
    fr_bad_cmd = clean ? 1'b0 : ($urandom_range(0, 7) == 0);
    if (!fr_has_cmd) begin
      fr_trunc = $urandom_range(0, 9);
      if (fr_n == 0 && fr_trunc == 0) fr_trunc = 3;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable_n = 1'b0; din = 1'b1; out_ready = 1'b1;
    idle(3);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if ({cur_out(), drop_cnt} !== 86'd0) $display("FAIL reset_outputs got=%h exp=0", {cur_out(), drop_cnt}); else n_pass++;
    rst = 1'b0; enable_n = 1'b1; din = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    res_t r;
    clear_frame();
    fr_n = 2; fr_pl[0] = 8'h12; fr_pl[1] = 8'h34; fr_cmd = 8'h01;
    send_cur();
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1) $display("FAIL basic_latency got=%b exp=1", out_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL basic_pulse got=%b exp=0", out_valid); else n_pass++;
    wait_result(r);
    n_chk++; if (r !== {8'h01, 4'd2, 64'h3412, 2'd0}) $display("FAIL basic_result got=%h exp=%h", r, {8'h01, 4'd2, 64'h3412, 2'd0}); else n_pass++;
    idle(4);
  endtask

  task automatic test_parity();
    res_t r;
    clear_frame();
    fr_n = 2; fr_pl[0] = 8'h12; fr_pl[1] = 8'h34; fr_bad[1] = 1'b1; fr_cmd = 8'h01;
    send_cur(); wait_result(r);
    n_chk++; if (r !== {8'h01, 4'd2, 64'h3412, 2'd1}) $display("FAIL parity_result got=%h exp=%h", r, {8'h01, 4'd2, 64'h3412, 2'd1}); else n_pass++;
    idle(4);
  endtask

  task automatic test_overflow();
    res_t r;
    clear_frame();
    fr_n = 9; fr_cmd = 8'h02;
    for (int i = 0; i < 9; i++) fr_pl[i] = 8'(i);
    send_cur(); wait_result(r);
    n_chk++; if (r !== {8'h02, 4'd8, 64'h0706050403020100, 2'd2}) $display("FAIL overflow_result got=%h exp=%h", r, {8'h02, 4'd8, 64'h0706050403020100, 2'd2}); else n_pass++;
    idle(4);
  endtask

  task automatic test_framing();
    res_t r;
    clear_frame();
    fr_n = 1; fr_pl[0] = 8'hA5; fr_has_cmd = 1'b0; fr_trunc = 5;
    send_cur(); wait_result(r);
    n_chk++; if (r !== {8'h00, 4'd1, 64'hA5, 2'd3}) $display("FAIL framing_result got=%h exp=%h", r, {8'h00, 4'd1, 64'hA5, 2'd3}); else n_pass++;
    n_chk++; if (got_q.size() !== 0) $display("FAIL framing_single got=%0d exp=0", got_q.size()); else n_pass++;
    idle(4);
  endtask

  task automatic test_random();
    res_t r, e;
    for (int f = 0; f < 25; f++) begin
      rand_frame(1'b0);
      e = model();
      send_cur(); wait_result(r);
      n_chk++; if (r !== e) $display("FAIL random_%0d got=%h exp=%h", f, r, e); else n_pass++;
      idle($urandom_range(4, 6));
    end
  endtask

  res_t held_e;

  task automatic test_hold_drop();
    out_ready = 1'b0;
    rand_frame(1'b0); fr_has_cmd = 1'b1;
    held_e = model();
    send_cur(); idle(4);
    n_chk++; if (out_valid !== 1'b1 || cur_out() !== held_e) $display("FAIL hold_first got=%b/%h exp=1/%h", out_valid, cur_out(), held_e); else n_pass++;
    rand_frame(1'b0);
    send_cur(); idle(6);
    n_chk++; if (out_valid !== 1'b1 || cur_out() !== held_e) $display("FAIL hold_stable got=%b/%h exp=1/%h", out_valid, cur_out(), held_e); else n_pass++;
    n_chk++; if (drop_cnt !== 8'd1) $display("FAIL drop_count got=%0d exp=1", drop_cnt); else n_pass++;
    n_chk++; if (got_q.size() !== 0) $display("FAIL hold_no_transfer got=%0d exp=0", got_q.size()); else n_pass++;
  endtask

  // Release the held result on the same edge a new result loads.
  task automatic test_back_to_back();
    res_t r, e;
    rand_frame(1'b0); fr_has_cmd = 1'b1;
    e = model();
    send_cur();
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1 || cur_out() !== e) $display("FAIL b2b_load got=%b/%h exp=1/%h", out_valid, cur_out(), e); else n_pass++;
    n_chk++; if (drop_cnt !== 8'd1) $display("FAIL b2b_no_drop got=%0d exp=1", drop_cnt); else n_pass++;
    wait_result(r);
    n_chk++; if (r !== held_e) $display("FAIL b2b_first got=%h exp=%h", r, held_e); else n_pass++;
    wait_result(r);
    n_chk++; if (r !== e) $display("FAIL b2b_second got=%h exp=%h", r, e); else n_pass++;
    idle(4);
  endtask

  task automatic test_reset_midframe();
    res_t r, e;
    clear_frame();
    fr_n = 2; fr_pl[0] = 8'h5A; fr_pl[1] = 8'hC3;
    for (int i = 0; i < fr_n; i++) send_word(1'b0, fr_pl[i], 1'b0, 10);
    send_word(1'b1, 8'h55, 1'b0, 4);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; enable_n = 1'b1; din = 1'b0;
    idle(6);
    n_chk++; if (drop_cnt !== 8'd0) $display("FAIL rstmid_drop got=%0d exp=0", drop_cnt); else n_pass++;
    n_chk++; if (out_valid !== 1'b0 || got_q.size() !== 0) $display("FAIL rstmid_no_result got=%b/%0d exp=0/0", out_valid, got_q.size()); else n_pass++;
    rand_frame(1'b1);
    e = model();
    send_cur(); wait_result(r);
    n_chk++; if (r !== e || r[1:0] !== 2'd0) $display("FAIL rstmid_clean got=%h exp=%h", r, e); else n_pass++;
    idle(4);
  endtask

  initial begin
    rst = 1'b1; enable_n = 1'b1; din = 1'b0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_overflow();
    test_framing();
    test_random();
    test_hold_drop();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
